// File: rtl/key_uart_tx.sv
// Keypad-to-UART transmitter: maps scanner keys to ASCII, queues them in a byte FIFO and
// sends each one as an 8N1 frame. Define KEY_UART_CRLF_EN to append CR/LF after every '='.
module key_uart_tx #(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_value,
  input  logic       value_en,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow
);

  // state | meaning
  // IDLE  | line high; load next byte (CR/LF tail first, else FIFO head)
  // START | start bit (low) for BAUD_DIV cycles
  // DATA  | 8 data bits LSB first, BAUD_DIV cycles each
  // STOP  | stop bit (high) for BAUD_DIV cycles
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]   FIFO_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  function automatic logic [7:0] key_to_ascii(input logic [3:0] key);
    logic [7:0] ch;
    case (key)
      4'd10:   ch = 8'h2B;
      4'd11:   ch = 8'h2D;
      4'd12:   ch = 8'h2A;
      4'd13:   ch = 8'h2F;
      4'd14:   ch = 8'h3D;
      4'd15:   ch = 8'h43;
      default: ch = 8'h30 + {4'd0, key};
    endcase
    return ch;
  endfunction

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_accept;
  logic              pop;
  logic [7:0]        head_byte;

  state_t            state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shift_reg, shift_reg_n;
  logic              tx_n;
  logic              baud_tc;

`ifdef KEY_UART_CRLF_EN
  logic [1:0]        tail_cnt, tail_cnt_n;
  logic              eq_frame, eq_frame_n;
`endif

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  // A pop on the same edge frees a slot, so a write while full is still accepted.
  assign wr_accept  = value_en && (!fifo_full || pop);
  assign head_byte  = fifo_mem[rd_ptr];
  assign baud_tc    = (baud_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (wr_accept) begin
      fifo_mem[wr_ptr] <= key_to_ascii(key_value);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= value_en && fifo_full && !pop;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
`ifdef KEY_UART_CRLF_EN
      tail_cnt  <= '0;
      eq_frame  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      uart_tx   <= tx_n;
`ifdef KEY_UART_CRLF_EN
      tail_cnt  <= tail_cnt_n;
      eq_frame  <= eq_frame_n;
`endif
    end
  end

  // uart_tx is registered, so the line lags the state by one cycle.
  always_comb begin
    case (state)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    pop         = 1'b0;
`ifdef KEY_UART_CRLF_EN
    tail_cnt_n  = tail_cnt;
    eq_frame_n  = eq_frame;
`endif
    case (state)
      IDLE: begin
        baud_cnt_n = BAUD_LOAD;
        bit_cnt_n  = '0;
`ifdef KEY_UART_CRLF_EN
        if (tail_cnt != 2'd0) begin
          shift_reg_n = (tail_cnt == 2'd2) ? 8'h0D : 8'h0A;
          tail_cnt_n  = tail_cnt - 2'd1;
          eq_frame_n  = 1'b0;
          state_n     = START;
        end else
`endif
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_reg_n = head_byte;
`ifdef KEY_UART_CRLF_EN
          eq_frame_n  = (head_byte == 8'h3D);
`endif
          state_n     = START;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_cnt_n = BAUD_LOAD;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_cnt_n  = BAUD_LOAD;
          shift_reg_n = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          state_n = IDLE;
`ifdef KEY_UART_CRLF_EN
          if (eq_frame) begin
            tail_cnt_n = 2'd2;
          end
`endif
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef KEY_UART_CRLF_EN
  assign busy = !fifo_empty || (state != IDLE) || (tail_cnt != 2'd0);
`else
  assign busy = !fifo_empty || (state != IDLE);
`endif

endmodule

// File: tb/tb_key_uart_tx.sv
// Randomised self-checking bench for key_uart_tx: a queue-based reference model predicts
// bytes, frame start cycles, busy and overflow; a line monitor decodes uart_tx.
module tb_key_uart_tx;

  localparam int BD    = 24000000 / 115200;
  localparam int FR    = 10 * BD + 1;
  localparam int DEPTH = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       value_en = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic       overflow;

  key_uart_tx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_value (key_value),
    .value_en  (value_en),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ovf = 0;

  logic [7:0] m_q[$];
  int         m_free_at = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       mon_abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ascii(input int k);
    string ops;
    ops = "+-*/=C";
    if (k < 10) return 8'(8'h30 + k);
    return ops[k - 10];
  endfunction

  // Reference model: a byte queue plus the cycle at which the transmitter can take the next byte.
  always @(posedge sys_clk) begin
    logic [7:0] b;
    int nfr;
    cyc++;
    m_ovf = 1'b0;
    if (sys_rst_n) begin
      if (m_q.size() != 0 && cyc >= m_free_at) begin
        b = m_q.pop_front();
        exp_q.push_back(b);
        exp_t.push_back(cyc + 1);
        nfr = 1;
`ifdef KEY_UART_CRLF_EN
        if (b == 8'h3D) begin
          exp_q.push_back(8'h0D);
          exp_t.push_back(cyc + 1 + FR);
          exp_q.push_back(8'h0A);
          exp_t.push_back(cyc + 1 + 2 * FR);
          nfr = 3;
        end
`endif
        m_free_at = cyc + nfr * FR;
      end
      if (value_en) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(ascii(int'(key_value)));
      end
    end else begin
      m_q.delete();
      m_free_at = 0;
    end
  end

  always @(negedge sys_rst_n) begin
    m_q.delete();
    m_free_at = 0;
    m_ovf = 1'b0;
    mon_abort = 1'b1;
  end

  always @(negedge sys_clk) begin
    chk("busy", busy, (m_q.size() != 0) || (cyc < m_free_at - 1));
    chk("overflow", overflow, m_ovf);
    if (overflow === 1'b1) n_ovf++;
  end

  // Line monitor: mid-bit sampling of each 8N1 frame.
  initial begin
    logic [7:0] byte_r;
    logic start_ok, stop_ok;
    int t0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && uart_tx === 1'b0) begin
        t0 = cyc;
        mon_abort = 1'b0;
        repeat (BD / 2) @(negedge sys_clk);
        start_ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge sys_clk);
          byte_r[i] = uart_tx;
        end
        repeat (BD) @(negedge sys_clk);
        stop_ok = (uart_tx === 1'b1);
        if (!mon_abort) begin
          chk("start_bit", start_ok, 1'b1);
          chk("stop_bit", stop_ok, 1'b1);
          rx_q.push_back(byte_r);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic strobe(input int k);
    key_value = k[3:0];
    value_en = 1'b1;
    @(negedge sys_clk);
    value_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || m_q.size() != 0 || cyc < m_free_at) && n < 60000) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_timeout"}, n >= 60000, 1'b0);
    repeat (BD) @(negedge sys_clk);
  endtask

  task automatic compare_frames(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, rx_q[i], exp_q[i]);
      chk({tag, "_start"}, rx_t[i], exp_t[i]);
    end
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    exp_t.delete();
  endtask

  initial begin
    int bad;
    int n;
    int k;

    // reset held, no keys
    bad = 0;
    repeat (5000) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("t1_tx_idle", bad, 0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_overflow", overflow, 1'b0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // single key 7: latency, bits, busy afterwards
    strobe(7);
    chk("t2_tx_e0", uart_tx, 1'b1);
    @(negedge sys_clk);
    chk("t2_tx_e1", uart_tx, 1'b1);
    @(negedge sys_clk);
    chk("t2_tx_e2", uart_tx, 1'b0);
    wait_done("t2");
    chk("t2_nframes", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t2_byte7", rx_q[0], 8'h37);
    chk("t2_busy_after", busy, 1'b0);
    compare_frames("t2");

    // three consecutive keys
    strobe(1);
    strobe(2);
    strobe(3);
    wait_done("t3");
    compare_frames("t3");

    // ten consecutive keys: one drop
    n_ovf = 0;
    for (int i = 1; i <= 10; i++) strobe(i);
    wait_done("t4");
    chk("t4_nframes", rx_q.size(), 9);
    chk("t4_ovf_pulses", n_ovf, 1);
    compare_frames("t4");

    // '=' key
    strobe(14);
    wait_done("t5");
    chk("t5_busy_after", busy, 1'b0);
    compare_frames("t5");

    // random bursts
    for (int b = 0; b < 2; b++) begin
      n = (b == 0) ? $urandom_range(12, 6) : $urandom_range(5, 2);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(15, 0);
        strobe(k);
        repeat ($urandom_range(2, 0)) @(negedge sys_clk);
      end
      wait_done("rnd");
      compare_frames("rnd");
    end

    // reset during data bit 3
    strobe(7);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t6_start_seen", uart_tx, 1'b0);
    repeat (4 * BD + BD / 2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_tx_in_reset", uart_tx, 1'b1);
    chk("t6_busy_in_reset", busy, 1'b0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    exp_t.delete();
    rx_q.delete();
    rx_t.delete();
    bad = 0;
    repeat (3000) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("t6_line_idle", bad, 0);
    chk("t6_no_frame", rx_q.size(), 0);
    chk("t6_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
